// File: rtl/vc_allocator_islip_if.sv
// Bundled allocation signals of the iSLIP VC allocator.
// The slave modport is used by the allocator. The master modport is used by
// the upstream router logic, or by a testbench.
interface vc_allocator_islip_if #(
    parameter int PORT_NUM = 5,
    parameter int VC_NUM   = 2
);
    localparam int VC_TOTAL  = PORT_NUM * VC_NUM;
    localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    logic [VC_TOTAL-1:0]                idle_downstream_vc_i;
    logic [VC_TOTAL-1:0]                vc_to_allocate_i;
    logic [VC_TOTAL-1:0][PORT_SIZE-1:0] out_port_i;
    logic [VC_TOTAL-1:0][VC_SIZE-1:0]   vc_new_o;
    logic [VC_TOTAL-1:0]                vc_valid_o;
    logic [VC_TOTAL-1:0]                available_vc_o;

    modport master (
        output idle_downstream_vc_i,
        output vc_to_allocate_i,
        output out_port_i,
        input  vc_new_o,
        input  vc_valid_o,
        input  available_vc_o
    );

    modport slave (
        input  idle_downstream_vc_i,
        input  vc_to_allocate_i,
        input  out_port_i,
        output vc_new_o,
        output vc_valid_o,
        output available_vc_o
    );
endinterface

// File: rtl/vc_allocator_islip.sv
// Separable input-first VC allocator for the router VA stage. Each cycle it
// runs up to ITER iSLIP iterations. Round-robin pointers advance only on
// matches accepted in the first iteration. VCs can be split into classes.
// Grants are combinational; availability is registered.
// Optional: define VC_ALLOC_STARVE_EN to enable per-requester starvation
// counters. A requester whose counter has saturated pre-empts non-urgent
// requesters in every output stage.
module vc_allocator_islip #(
    parameter int PORT_NUM     = 5,
    parameter int VC_NUM       = 2,
    parameter int VC_SIZE      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    parameter int ITER         = 1,
    parameter int VC_CLASSES   = 1,
    parameter int STARVE_LIMIT = 15
) (
    input logic                 clk,
    input logic                 rst,
    vc_allocator_islip_if.slave bus
);
    localparam int unsigned VC_TOTAL  = PORT_NUM * VC_NUM;
    localparam int unsigned PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam int unsigned PTR_W     = (VC_TOTAL > 1) ? $clog2(VC_TOTAL) : 1;
    localparam int unsigned CLS_SIZE  = VC_NUM / VC_CLASSES;

    if (ITER < 1 || ITER > 3) begin : g_bad_iter
        $error("vc_allocator_islip: ITER must be 1..3");
    end
    if (VC_CLASSES < 1 || (VC_NUM % VC_CLASSES) != 0) begin : g_bad_classes
        $error("vc_allocator_islip: VC_CLASSES must divide VC_NUM");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve
        $error("vc_allocator_islip: STARVE_LIMIT must be at least 1");
    end

    logic [VC_TOTAL-1:0]            avail_q;
    logic [VC_TOTAL-1:0]            avail_nxt;
    logic [VC_TOTAL-1:0][PTR_W-1:0] ptr_in_q;
    logic [VC_TOTAL-1:0][PTR_W-1:0] ptr_in_nxt;
    logic [VC_TOTAL-1:0][PTR_W-1:0] ptr_out_q;
    logic [VC_TOTAL-1:0][PTR_W-1:0] ptr_out_nxt;

    logic [VC_TOTAL-1:0]            req [VC_TOTAL];
    logic [VC_TOTAL-1:0]            gnt_in [VC_TOTAL];
    logic [VC_TOTAL-1:0]            match_u;
    logic [VC_TOTAL-1:0]            match_d;
    logic [VC_TOTAL-1:0][PTR_W-1:0] match_idx;
    logic [VC_TOTAL-1:0]            urgent;

    // Returns (base + k) mod VC_TOTAL. Requires base < VC_TOTAL and k < VC_TOTAL.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int unsigned      k);
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + (PTR_W+1)'(k);
        if (sum >= (PTR_W+1)'(VC_TOTAL)) begin
            sum = sum - (PTR_W+1)'(VC_TOTAL);
        end
        return sum[PTR_W-1:0];
    endfunction

    // Class of a global VC index.
    function automatic int unsigned cls_of(input int unsigned v);
        return (v % VC_NUM) / CLS_SIZE;
    endfunction

    // Request matrix: the VC is available, on the routed port, and in the same class.
    always_comb begin
        for (int unsigned u = 0; u < VC_TOTAL; u++) begin
            req[u] = '0;
            for (int unsigned d = 0; d < VC_TOTAL; d++) begin
                req[u][d] = bus.vc_to_allocate_i[u] & avail_q[d]
                          & (bus.out_port_i[u] == PORT_SIZE'(d / VC_NUM))
                          & (cls_of(u) == cls_of(d));
            end
        end
    end

    // iSLIP iterations: an input-stage grant, then an output-stage accept.
    // Later iterations see only pairs left unmatched by earlier iterations.
    // Pointers move only on matches accepted in the first iteration.
    always_comb begin
        logic [PTR_W-1:0] idx;
        logic             found;
        logic             any_urgent;
        match_u     = '0;
        match_d     = '0;
        match_idx   = '0;
        ptr_in_nxt  = ptr_in_q;
        ptr_out_nxt = ptr_out_q;
        idx         = '0;
        found       = 1'b0;
        any_urgent  = 1'b0;
        for (int unsigned u = 0; u < VC_TOTAL; u++) begin
            gnt_in[u] = '0;
        end
        for (int unsigned it = 0; it < ITER; it++) begin
            for (int unsigned u = 0; u < VC_TOTAL; u++) begin
                gnt_in[u] = '0;
                found     = 1'b0;
                if (!match_u[u]) begin
                    for (int unsigned k = 0; k < VC_TOTAL; k++) begin
                        idx = wrap_add(ptr_in_q[u], k);
                        if (!found && req[u][idx] && !match_d[idx]) begin
                            gnt_in[u][idx] = 1'b1;
                            found          = 1'b1;
                        end
                    end
                end
            end
            for (int unsigned d = 0; d < VC_TOTAL; d++) begin
                if (!match_d[d]) begin
                    any_urgent = 1'b0;
                    for (int unsigned u = 0; u < VC_TOTAL; u++) begin
                        if (gnt_in[u][d] && urgent[u]) begin
                            any_urgent = 1'b1;
                        end
                    end
                    found = 1'b0;
                    for (int unsigned k = 0; k < VC_TOTAL; k++) begin
                        idx = wrap_add(ptr_out_q[d], k);
                        if (!found && gnt_in[idx][d] && (urgent[idx] || !any_urgent)) begin
                            found          = 1'b1;
                            match_u[idx]   = 1'b1;
                            match_d[d]     = 1'b1;
                            match_idx[idx] = PTR_W'(d);
                            if (it == 0) begin
                                ptr_in_nxt[idx] = wrap_add(PTR_W'(d), 1);
                                ptr_out_nxt[d]  = wrap_add(idx, 1);
                            end
                        end
                    end
                end
            end
        end
    end

    // A matched VC becomes busy. An idle report frees a busy VC.
    // A match always needs avail=1, so the two cases never overlap.
    always_comb begin
        avail_nxt = (avail_q | bus.idle_downstream_vc_i) & ~match_d;
    end

    // Availability and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            avail_q   <= '1;
            ptr_in_q  <= '0;
            ptr_out_q <= '0;
        end else begin
            avail_q   <= avail_nxt;
            ptr_in_q  <= ptr_in_nxt;
            ptr_out_q <= ptr_out_nxt;
        end
    end

`ifdef VC_ALLOC_STARVE_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [VC_TOTAL-1:0][STARVE_W-1:0] starve_q;

    // A requester becomes urgent once its starvation counter saturates.
    always_comb begin
        for (int unsigned u = 0; u < VC_TOTAL; u++) begin
            urgent[u] = (starve_q[u] == STARVE_W'(STARVE_LIMIT));
        end
    end

    // Count consecutive denied cycles and saturate at the limit.
    // The count clears on a grant or when the request drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            for (int unsigned u = 0; u < VC_TOTAL; u++) begin
                if (bus.vc_to_allocate_i[u] && !match_u[u]) begin
                    if (starve_q[u] != STARVE_W'(STARVE_LIMIT)) begin
                        starve_q[u] <= starve_q[u] + STARVE_W'(1);
                    end
                end else begin
                    starve_q[u] <= '0;
                end
            end
        end
    end
`else
    // Without starvation tracking no requester is ever urgent.
    always_comb begin
        urgent = '0;
    end
`endif

    // Zero-latency grant outputs. While reset is asserted they are forced
    // to their idle values.
    always_comb begin
        bus.vc_valid_o     = rst ? match_u : '0;
        bus.available_vc_o = rst ? avail_q : '1;
        bus.vc_new_o       = '0;
        for (int unsigned u = 0; u < VC_TOTAL; u++) begin
            if (rst && match_u[u]) begin
                bus.vc_new_o[u] = VC_SIZE'(32'(match_idx[u]) % 32'(VC_NUM));
            end
        end
    end
endmodule

// File: tb/tb_vc_allocator_islip.sv
// Directed self-checking bench for vc_allocator_islip (default build).
// Three instances are used: default parameters, ITER=2, and VC_CLASSES=2.
module tb_vc_allocator_islip;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vc_allocator_islip_if #(.PORT_NUM(5), .VC_NUM(2)) ifa ();
    vc_allocator_islip_if #(.PORT_NUM(5), .VC_NUM(2)) ifb ();
    vc_allocator_islip_if #(.PORT_NUM(5), .VC_NUM(2)) ifc ();

    vc_allocator_islip #(.PORT_NUM(5), .VC_NUM(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    vc_allocator_islip #(.PORT_NUM(5), .VC_NUM(2), .ITER(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    vc_allocator_islip #(.PORT_NUM(5), .VC_NUM(2), .VC_CLASSES(2)) dut_c (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        ifa.vc_to_allocate_i = '0; ifa.idle_downstream_vc_i = '0; ifa.out_port_i = '0;
        ifb.vc_to_allocate_i = '0; ifb.idle_downstream_vc_i = '0; ifb.out_port_i = '0;
        ifc.vc_to_allocate_i = '0; ifc.idle_downstream_vc_i = '0; ifc.out_port_i = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: every u requests port 1 while reset is held
        ifa.vc_to_allocate_i = 10'h3FF;
        for (int i = 0; i < 10; i++) ifa.out_port_i[i] = 3'd1;
        #1;
        chk("rst_valid", 32'(ifa.vc_valid_o), 32'h000);
        chk("rst_vcnew", 32'(ifa.vc_new_o), 32'h000);
        chk("rst_avail", 32'(ifa.available_vc_o), 32'h3FF);
        @(posedge clk); #1;
        chk("rst_hold_avail", 32'(ifa.available_vc_o), 32'h3FF);
        chk("rst_hold_valid", 32'(ifa.vc_valid_o), 32'h000);

        // Scenario 1 (ITER=1): release reset in mid-cycle
        #2 rst = 1'b1; #1;
        chk("s1_c1_valid", 32'(ifa.vc_valid_o), 32'h001);
        chk("s1_c1_vcnew", 32'(ifa.vc_new_o), 32'h000);
        @(posedge clk); #1;
        ifa.vc_to_allocate_i = 10'h3FE; #1;
        chk("s1_c2_avail", 32'(ifa.available_vc_o), 32'h3FB);
        chk("s1_c2_valid", 32'(ifa.vc_valid_o), 32'h002);
        chk("s1_c2_vcnew", 32'(ifa.vc_new_o), 32'h002);
        @(posedge clk); #1;
        ifa.vc_to_allocate_i = 10'h3FC; ifa.idle_downstream_vc_i = 10'h004; #1;
        chk("s1_c3_avail", 32'(ifa.available_vc_o), 32'h3F3);
        chk("s1_c3_valid", 32'(ifa.vc_valid_o), 32'h000);
        @(posedge clk); #1;
        ifa.idle_downstream_vc_i = '0; #1;
        chk("s1_c4_avail", 32'(ifa.available_vc_o), 32'h3F7);
        chk("s1_c4_valid", 32'(ifa.vc_valid_o), 32'h004);
        chk("s1_c4_vcnew", 32'(ifa.vc_new_o), 32'h000);

        // Asynchronous reset in mid-cycle while a grant is active
        #2 rst = 1'b0; #1;
        chk("mrst_valid", 32'(ifa.vc_valid_o), 32'h000);
        chk("mrst_avail", 32'(ifa.available_vc_o), 32'h3FF);
        chk("mrst_vcnew", 32'(ifa.vc_new_o), 32'h000);
        ifa.vc_to_allocate_i = 10'h3FF;
        #2 rst = 1'b1; #1;
        chk("mrst_rel_valid", 32'(ifa.vc_valid_o), 32'h001);
        @(posedge clk); #1;
        ifa.vc_to_allocate_i = 10'h3FE; #1;
        chk("mrst_c2_valid", 32'(ifa.vc_valid_o), 32'h002);
        chk("mrst_c2_vcnew", 32'(ifa.vc_new_o), 32'h002);
        chk("mrst_c2_avail", 32'(ifa.available_vc_o), 32'h3FB);

        // Fairness on port 3: u5 first takes d6 and d7, then d6 is freed
        rst = 1'b0;
        ifa.vc_to_allocate_i = '0;
        for (int i = 0; i < 10; i++) ifa.out_port_i[i] = 3'd3;
        @(posedge clk); #1;
        rst = 1'b1; ifa.vc_to_allocate_i = 10'h020; #1;
        chk("fair_u5_a_valid", 32'(ifa.vc_valid_o), 32'h020);
        chk("fair_u5_a_vcnew", 32'(ifa.vc_new_o), 32'h000);
        @(posedge clk); #1; #1;
        chk("fair_u5_b_avail", 32'(ifa.available_vc_o), 32'h3BF);
        chk("fair_u5_b_valid", 32'(ifa.vc_valid_o), 32'h020);
        chk("fair_u5_b_vcnew", 32'(ifa.vc_new_o), 32'h020);
        @(posedge clk); #1;
        // idle on d8, which is already available, must have no effect
        ifa.vc_to_allocate_i = '0; ifa.idle_downstream_vc_i = 10'h140; #1;
        chk("fair_free_avail", 32'(ifa.available_vc_o), 32'h33F);
        chk("fair_free_valid", 32'(ifa.vc_valid_o), 32'h000);
        @(posedge clk); #1;
        ifa.idle_downstream_vc_i = '0; ifa.vc_to_allocate_i = 10'h011; #1;
        chk("fair_g0_avail", 32'(ifa.available_vc_o), 32'h37F);
        chk("fair_g0_valid", 32'(ifa.vc_valid_o), 32'h001);
        chk("fair_g0_vcnew", 32'(ifa.vc_new_o), 32'h000);
        for (int r = 0; r < 3; r++) begin
            @(posedge clk); #1;
            ifa.idle_downstream_vc_i = 10'h040; #1;
            chk("fair_gap_valid", 32'(ifa.vc_valid_o), 32'h000);
            chk("fair_gap_avail", 32'(ifa.available_vc_o), 32'h33F);
            @(posedge clk); #1;
            ifa.idle_downstream_vc_i = '0; #1;
            chk("fair_grant_valid", 32'(ifa.vc_valid_o), (r % 2 == 0) ? 32'h010 : 32'h001);
            chk("fair_grant_avail", 32'(ifa.available_vc_o), 32'h37F);
        end

        // Scenario 2: ITER=2 fills both port-1 VCs in a single cycle
        rst = 1'b0;
        ifa.vc_to_allocate_i = '0;
        ifb.vc_to_allocate_i = 10'h3FF;
        for (int i = 0; i < 10; i++) ifb.out_port_i[i] = 3'd1;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("it2_c1_valid", 32'(ifb.vc_valid_o), 32'h003);
        chk("it2_c1_vcnew", 32'(ifb.vc_new_o), 32'h002);
        @(posedge clk); #1;
        ifb.vc_to_allocate_i = 10'h3FC; ifb.idle_downstream_vc_i = 10'h004; #1;
        chk("it2_c2_avail", 32'(ifb.available_vc_o), 32'h3F3);
        chk("it2_c2_valid", 32'(ifb.vc_valid_o), 32'h000);
        @(posedge clk); #1;
        ifb.idle_downstream_vc_i = '0; #1;
        chk("it2_c3_avail", 32'(ifb.available_vc_o), 32'h3F7);
        chk("it2_c3_valid", 32'(ifb.vc_valid_o), 32'h004);
        chk("it2_c3_vcnew", 32'(ifb.vc_new_o), 32'h000);

        // Scenario 3: two VC classes share port 2 in the same cycle
        rst = 1'b0;
        ifb.vc_to_allocate_i = '0;
        ifc.out_port_i[0] = 3'd2; ifc.out_port_i[1] = 3'd2;
        ifc.vc_to_allocate_i = 10'h003;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("cls_valid", 32'(ifc.vc_valid_o), 32'h003);
        chk("cls_vcnew", 32'(ifc.vc_new_o), 32'h002);
        @(posedge clk); #1;
        ifc.vc_to_allocate_i = '0; #1;
        chk("cls_avail", 32'(ifc.available_vc_o), 32'h3CF);
        chk("cls_idle_valid", 32'(ifc.vc_valid_o), 32'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
